// File: rtl/day_10_press_solver_stream.sv
// Streams machine descriptors in, runs a bounded odometer search for the minimum
// total button presses per machine, and streams per-machine results out with a running total.
module day_10_press_solver_stream #(
  parameter int MAX_BUTTONS  = 8,
  parameter int MAX_COUNTERS = 8,
  parameter int CNT_W        = 16,
  parameter int SUM_W        = 64,
  parameter int MAX_ITER     = 1048576
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [3:0]                      in_num_buttons,
  input  logic [3:0]                      in_num_counters,
  input  logic [MAX_BUTTONS*MAX_COUNTERS-1:0] in_buttons,
  input  logic [MAX_COUNTERS*CNT_W-1:0]   in_targets,
  input  logic                            in_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [CNT_W+3:0]                out_presses,
  output logic                            out_infeasible,
  output logic                            out_timeout,
  output logic [SUM_W-1:0]                total,
  output logic                            finished,
  input  logic                            clear
);

  localparam int PW = CNT_W + 4;
  localparam int IW = $clog2(MAX_ITER) + 1;

  typedef enum logic [1:0] {IDLE, BOUND, SEARCH, REPORT} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              nb_q, nb_d, nc_q, nc_d;
  logic [MAX_COUNTERS-1:0] mask_q [MAX_BUTTONS];
  logic [MAX_COUNTERS-1:0] mask_d [MAX_BUTTONS];
  logic [CNT_W-1:0]        target_q [MAX_COUNTERS];
  logic [CNT_W-1:0]        target_d [MAX_COUNTERS];
  logic [CNT_W-1:0]        bound_q [MAX_BUTTONS];
  logic [CNT_W-1:0]        bound_d [MAX_BUTTONS];
  logic [CNT_W-1:0]        press_q [MAX_BUTTONS];
  logic [CNT_W-1:0]        press_d [MAX_BUTTONS];
  logic [PW-1:0]           best_q, best_d;
  logic [IW-1:0]           iter_q, iter_d;
  logic                    timeout_q, timeout_d;
  logic                    last_q, last_d;
  logic                    finished_q, finished_d;
  logic [SUM_W-1:0]        total_q, total_d;

  logic [3:0]              nb_sat, nc_sat;
  logic [CNT_W-1:0]        bound_calc [MAX_BUTTONS];
  logic [CNT_W-1:0]        press_step [MAX_BUTTONS];
  logic [PW-1:0]           cnt;
  logic                    match, done;

  assign nb_sat = (int'(in_num_buttons) > MAX_BUTTONS) ? 4'(MAX_BUTTONS) : in_num_buttons;
  assign nc_sat = (int'(in_num_counters) > MAX_COUNTERS) ? 4'(MAX_COUNTERS) : in_num_counters;

  // Captured masks/targets are pre-zeroed outside the used region, so evaluation runs over the full arrays.
  always_comb begin : eval_p
    logic [CNT_W-1:0] mn;
    logic [PW-1:0]    s;
    logic             carry;
    cnt   = '0;
    match = 1'b1;
    carry = 1'b1;
    for (int i = 0; i < MAX_BUTTONS; i++) begin
      mn = '1;
      for (int j = 0; j < MAX_COUNTERS; j++) begin
        if (mask_q[i][j] && target_q[j] < mn) mn = target_q[j];
      end
      bound_calc[i] = (|mask_q[i]) ? mn : '0;
      cnt           = cnt + PW'(press_q[i]);
      press_step[i] = press_q[i];
      if (carry && i < int'(nb_q)) begin
        if (press_q[i] == bound_q[i]) begin
          press_step[i] = '0;
        end else begin
          press_step[i] = press_q[i] + 1'b1;
          carry         = 1'b0;
        end
      end
    end
    for (int j = 0; j < MAX_COUNTERS; j++) begin
      s = '0;
      for (int i = 0; i < MAX_BUTTONS; i++) begin
        if (mask_q[i][j]) s = s + PW'(press_q[i]);
      end
      if (s != PW'(target_q[j])) match = 1'b0;
    end
    done = carry;
  end

  always_comb begin : next_p
    state_d    = state_q;
    nb_d       = nb_q;
    nc_d       = nc_q;
    mask_d     = mask_q;
    target_d   = target_q;
    bound_d    = bound_q;
    press_d    = press_q;
    best_d     = best_q;
    iter_d     = iter_q;
    timeout_d  = timeout_q;
    last_d     = last_q;
    finished_d = finished_q;
    total_d    = total_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          total_d    = '0;
          finished_d = 1'b0;
        end
        if (in_valid) begin
          nb_d   = nb_sat;
          nc_d   = nc_sat;
          last_d = in_last;
          for (int i = 0; i < MAX_BUTTONS; i++) begin
            for (int j = 0; j < MAX_COUNTERS; j++) begin
              mask_d[i][j] = (i < int'(nb_sat) && j < int'(nc_sat)) ?
                             in_buttons[i*MAX_COUNTERS+j] : 1'b0;
            end
          end
          for (int j = 0; j < MAX_COUNTERS; j++) begin
            target_d[j] = (j < int'(nc_sat)) ? in_targets[j*CNT_W +: CNT_W] : '0;
          end
          state_d = BOUND;
        end
      end
      BOUND: begin
        bound_d   = bound_calc;
        for (int i = 0; i < MAX_BUTTONS; i++) press_d[i] = '0;
        best_d    = '1;
        iter_d    = '0;
        timeout_d = 1'b0;
        state_d   = SEARCH;
      end
      SEARCH: begin
        if (match && cnt < best_q) best_d = cnt;
        press_d = press_step;
        iter_d  = iter_q + 1'b1;
        if (done) begin
          state_d = REPORT;
        end else if (iter_q == IW'(MAX_ITER - 1)) begin
          timeout_d = 1'b1;
          state_d   = REPORT;
        end
      end
      REPORT: begin
        if (out_ready) begin
          // A partial best found before timeout still counts toward the total.
          if (best_q != '1) total_d = total_q + SUM_W'(best_q);
          if (last_q) finished_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      nb_q       <= '0;
      nc_q       <= '0;
      best_q     <= '0;
      iter_q     <= '0;
      timeout_q  <= 1'b0;
      last_q     <= 1'b0;
      finished_q <= 1'b0;
      total_q    <= '0;
      for (int i = 0; i < MAX_BUTTONS; i++) begin
        mask_q[i]  <= '0;
        bound_q[i] <= '0;
        press_q[i] <= '0;
      end
      for (int j = 0; j < MAX_COUNTERS; j++) target_q[j] <= '0;
    end else begin
      state_q    <= state_d;
      nb_q       <= nb_d;
      nc_q       <= nc_d;
      mask_q     <= mask_d;
      target_q   <= target_d;
      bound_q    <= bound_d;
      press_q    <= press_d;
      best_q     <= best_d;
      iter_q     <= iter_d;
      timeout_q  <= timeout_d;
      last_q     <= last_d;
      finished_q <= finished_d;
      total_q    <= total_d;
    end
  end

  assign in_ready       = (state_q == IDLE);
  assign out_valid      = (state_q == REPORT);
  assign out_presses    = out_valid ? best_q : '0;
  assign out_infeasible = out_valid && (best_q == '1) && !timeout_q;
  assign out_timeout    = out_valid && timeout_q;
  assign total          = total_q;
  assign finished       = finished_q;

endmodule

// File: tb/tb_day_10_press_solver_stream.sv
// Bench for day_10_press_solver_stream: directed puzzle machines plus random descriptors
// against an enumerating reference model; a second instance uses a tiny iteration budget.
module tb_day_10_press_solver_stream;

  localparam logic [19:0] ALL1 = 20'hFFFFF;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   in_num_buttons, in_num_counters;
  logic [63:0]  in_buttons;
  logic [127:0] in_targets;
  logic         in_last, clear;

  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [19:0]  a_out_presses;
  logic         a_out_infeasible, a_out_timeout, a_finished;
  logic [63:0]  a_total;
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [19:0]  b_out_presses;
  logic         b_out_infeasible, b_out_timeout, b_finished;
  logic [63:0]  b_total;

  bit           sel;
  logic         o_in_ready, o_valid, o_infeas, o_timeout;
  logic [19:0]  o_presses;

  int           n_total = 0;
  int           n_bad = 0;
  logic [63:0]  tot_m;
  bit           fin_m;
  logic [19:0]  got_presses;

  always #5 clk = ~clk;

  day_10_press_solver_stream dut (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_num_buttons(in_num_buttons), .in_num_counters(in_num_counters),
    .in_buttons(in_buttons), .in_targets(in_targets), .in_last(in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_presses(a_out_presses),
    .out_infeasible(a_out_infeasible), .out_timeout(a_out_timeout),
    .total(a_total), .finished(a_finished), .clear(clear)
  );

  day_10_press_solver_stream #(.MAX_ITER(16)) dut_t (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_num_buttons(in_num_buttons), .in_num_counters(in_num_counters),
    .in_buttons(in_buttons), .in_targets(in_targets), .in_last(in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_presses(b_out_presses),
    .out_infeasible(b_out_infeasible), .out_timeout(b_out_timeout),
    .total(b_total), .finished(b_finished), .clear(clear)
  );

  assign o_in_ready = sel ? b_in_ready       : a_in_ready;
  assign o_valid    = sel ? b_out_valid      : a_out_valid;
  assign o_presses  = sel ? b_out_presses    : a_out_presses;
  assign o_infeas   = sel ? b_out_infeasible : a_out_infeasible;
  assign o_timeout  = sel ? b_out_timeout    : a_out_timeout;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_btn(input int i, input logic [7:0] m);
    in_buttons[i*8 +: 8] = m;
  endtask

  task automatic set_tgt(input int j, input int v);
    in_targets[j*16 +: 16] = 16'(v);
  endtask

  task automatic new_desc(input int nb, input int nc);
    in_buttons      = '0;
    in_targets      = '0;
    in_num_buttons  = 4'(nb);
    in_num_counters = 4'(nc);
  endtask

  // Enumerates combinations as mixed-radix integers, digit 0 least significant.
  task automatic model(input int max_iter, output logic [19:0] best, output bit to, output int combos);
    int nb, nc, mn, rem, cnt, s;
    int bnd[8];
    int p[8];
    longint prod, lim;
    bit ok;
    nb = (in_num_buttons > 8) ? 8 : int'(in_num_buttons);
    nc = (in_num_counters > 8) ? 8 : int'(in_num_counters);
    prod = 1;
    for (int i = 0; i < nb; i++) begin
      mn = -1;
      for (int j = 0; j < nc; j++)
        if (in_buttons[i*8+j] && (mn < 0 || int'(in_targets[j*16 +: 16]) < mn))
          mn = int'(in_targets[j*16 +: 16]);
      bnd[i] = (mn < 0) ? 0 : mn;
      prod = prod * (bnd[i] + 1);
    end
    to = (prod > max_iter);
    lim = to ? longint'(max_iter) : prod;
    combos = int'(lim);
    best = ALL1;
    for (longint k = 0; k < lim; k++) begin
      rem = int'(k);
      cnt = 0;
      for (int i = 0; i < nb; i++) begin
        p[i] = rem % (bnd[i] + 1);
        rem  = rem / (bnd[i] + 1);
        cnt += p[i];
      end
      ok = 1;
      for (int j = 0; j < nc; j++) begin
        s = 0;
        for (int i = 0; i < nb; i++) if (in_buttons[i*8+j]) s += p[i];
        if (s != int'(in_targets[j*16 +: 16])) ok = 0;
      end
      if (ok && cnt < int'(best)) best = 20'(cnt);
    end
  endtask

  task automatic run_machine(input bit last, input bit pre_ready, input int hold, input bit clr_busy);
    logic [19:0] mb;
    bit mt;
    int mc, cyc;
    model(sel ? 16 : 1048576, mb, mt, mc);
    @(negedge clk);
    in_last = last;
    chk("in_ready_idle", o_in_ready, 1);
    if (sel) b_in_valid = 1; else a_in_valid = 1;
    if (pre_ready) begin
      if (sel) b_out_ready = 1; else a_out_ready = 1;
    end
    @(posedge clk);
    #1;
    a_in_valid = 0;
    b_in_valid = 0;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("in_ready_busy", o_in_ready, 0);
      clear = (clr_busy && cyc == 3);
      if (o_valid || cyc > mc + 20) break;
    end
    clear = 0;
    chk("out_valid", o_valid, 1);
    chk("latency", cyc, mc + 2);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_presses", o_presses, mb);
      chk("hold_valid", o_valid, 1);
      chk("hold_in_ready", o_in_ready, 0);
    end
    chk("presses", o_presses, mb);
    chk("infeasible", o_infeas, (mb == ALL1) && !mt);
    chk("timeout", o_timeout, mt);
    got_presses = o_presses;
    if (sel) b_out_ready = 1; else a_out_ready = 1;
    @(posedge clk);
    #1;
    a_out_ready = 0;
    b_out_ready = 0;
    @(negedge clk);
    chk("report_done", o_valid, 0);
    if (!sel) begin
      if (mb != ALL1) tot_m = tot_m + 64'(mb);
      if (last) fin_m = 1;
      chk("total", a_total, tot_m);
      chk("finished", a_finished, fin_m);
    end
  endtask

  task automatic load_m1();
    new_desc(6, 4);
    set_btn(0, 8'b00001000); set_btn(1, 8'b00001010); set_btn(2, 8'b00000100);
    set_btn(3, 8'b00001100); set_btn(4, 8'b00000101); set_btn(5, 8'b00000011);
    set_tgt(0, 3); set_tgt(1, 5); set_tgt(2, 4); set_tgt(3, 7);
  endtask

  task automatic load_zero();
    new_desc(3, 4);
    set_btn(0, 8'b0101); set_btn(1, 8'b1010); set_btn(2, 8'b1111);
  endtask

  initial begin
    int nbr, ncr, ncs, tmax;
    rst = 1; sel = 0; clear = 0; in_last = 0;
    a_in_valid = 0; a_out_ready = 0; b_in_valid = 0; b_out_ready = 0;
    new_desc(0, 0);
    tot_m = 0; fin_m = 0;
    #1;
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_presses", a_out_presses, 0);
    chk("rst_infeasible", a_out_infeasible, 0);
    chk("rst_timeout", a_out_timeout, 0);
    chk("rst_total", a_total, 0);
    chk("rst_finished", a_finished, 0);
    repeat (2) @(negedge clk);
    rst = 0;

    load_m1();
    run_machine(0, 0, 0, 0);
    chk("m1_presses", got_presses, 10);

    new_desc(5, 5);
    set_btn(0, 8'b00011101); set_btn(1, 8'b00001100); set_btn(2, 8'b00010001);
    set_btn(3, 8'b00000111); set_btn(4, 8'b00011110);
    set_tgt(0, 7); set_tgt(1, 5); set_tgt(2, 12); set_tgt(3, 7); set_tgt(4, 2);
    run_machine(0, 0, 0, 1);
    chk("m2_presses", got_presses, 12);
    chk("m2_total_clear_ignored", a_total, 22);

    new_desc(4, 6);
    set_btn(0, 8'b00011111); set_btn(1, 8'b00011001); set_btn(2, 8'b00110111); set_btn(3, 8'b00000110);
    set_tgt(0, 10); set_tgt(1, 11); set_tgt(2, 11); set_tgt(3, 5); set_tgt(4, 10); set_tgt(5, 5);
    run_machine(1, 0, 0, 0);
    chk("m3_presses", got_presses, 11);
    chk("m3_total", a_total, 33);
    chk("m3_finished", a_finished, 1);

    new_desc(1, 2);
    set_btn(0, 8'b00000001);
    set_tgt(0, 0); set_tgt(1, 4);
    run_machine(0, 0, 0, 0);
    chk("infeas_presses", got_presses, ALL1);
    chk("infeas_total", a_total, 33);

    load_zero();
    run_machine(0, 0, 5, 0);
    chk("zero_presses", got_presses, 0);

    for (int r = 0; r < 8; r++) begin
      if (r % 2 == 0) begin nbr = $urandom_range(0, 15); tmax = 1; end
      else begin nbr = $urandom_range(0, 5); tmax = 3; end
      ncr = $urandom_range(0, 15);
      ncs = (ncr > 8) ? 8 : ncr;
      new_desc(nbr, ncr);
      in_buttons = {$urandom, $urandom};
      for (int j = 0; j < 8; j++)
        set_tgt(j, (j < ncs) ? int'($urandom_range(0, tmax)) : int'($urandom_range(0, 65535)));
      run_machine(0, (r % 3 == 0), 0, 0);
    end

    load_m1();
    @(negedge clk);
    a_in_valid = 1;
    @(posedge clk);
    #1;
    a_in_valid = 0;
    repeat (30) @(negedge clk);
    chk("busy_before_rst", a_in_ready, 0);
    rst = 1;
    #1;
    chk("midrst_in_ready", a_in_ready, 1);
    chk("midrst_out_valid", a_out_valid, 0);
    chk("midrst_presses", a_out_presses, 0);
    chk("midrst_total", a_total, 0);
    chk("midrst_finished", a_finished, 0);
    @(negedge clk);
    rst = 0;
    tot_m = 0;
    fin_m = 0;
    repeat (40) @(negedge clk);
    chk("midrst_no_result", a_out_valid, 0);

    new_desc(4, 6);
    set_btn(0, 8'b00011111); set_btn(1, 8'b00011001); set_btn(2, 8'b00110111); set_btn(3, 8'b00000110);
    set_tgt(0, 10); set_tgt(1, 11); set_tgt(2, 11); set_tgt(3, 5); set_tgt(4, 10); set_tgt(5, 5);
    run_machine(1, 1, 0, 0);
    @(negedge clk);
    clear = 1;
    @(negedge clk);
    clear = 0;
    tot_m = 0;
    fin_m = 0;
    chk("clear_total", a_total, tot_m);
    chk("clear_finished", a_finished, fin_m);

    sel = 1;
    load_m1();
    run_machine(0, 0, 0, 0);
    load_zero();
    run_machine(0, 0, 0, 0);
    chk("after_timeout_presses", got_presses, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/day_10_press_solver_stream.md
Name: day_10_press_solver_stream

Overview:
- Parametrised successor of the day-10 joltage solver. Buttons, counters and machine count are no longer fixed, and machines are no longer preloaded from memory files: each machine arrives as one descriptor over a valid/ready stream.
- For each machine the block runs an exhaustive bounded odometer search for the minimum total button presses that drive every counter exactly to its target.
- Per-machine results leave on a valid/ready output stream with infeasible/timeout flags. A running 64-bit total is kept for the whole puzzle.

Parameters:
- MAX_BUTTONS, 8, maximum buttons per machine.
- MAX_COUNTERS, 8, maximum joltage counters per machine.
- CNT_W, 16, width of a target value and of each press counter.
- SUM_W, 64, width of the running total.
- MAX_ITER, 1048576, combination budget per machine before timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  block can accept a descriptor.
- in_num_buttons  in  4  buttons used; values above MAX_BUTTONS saturate to MAX_BUTTONS.
- in_num_counters  in  4  counters used; values above MAX_COUNTERS saturate.
- in_buttons  in  MAX_BUTTONS*MAX_COUNTERS  button i mask at bits [i*MAX_COUNTERS +: MAX_COUNTERS].
- in_targets  in  MAX_COUNTERS*CNT_W  target j at [j*CNT_W +: CNT_W].
- in_last  in  1  final machine of the puzzle.
- out_valid  out  1  per-machine result valid.
- out_ready  in  1  consumer accepts result.
- out_presses  out  CNT_W+4  minimum presses; all-ones if no solution.
- out_infeasible  out  1  no solution found in the full space.
- out_timeout  out  1  MAX_ITER exhausted before the space was covered.
- total  out  SUM_W  sum of feasible out_presses since reset/clear.
- finished  out  1  set after the in_last machine's result is accepted.
- clear  in  1  synchronous; zeroes total and finished, honoured only in IDLE.

Behaviour:
- Reset values:
  - State IDLE.
  - in_ready=1; out_valid=0; out_presses=0; out_infeasible=0; out_timeout=0; total=0; finished=0.
  - All internal press counters, bounds and best registers are 0.
  - Reset asserted mid-search aborts the machine. No result is emitted.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture the descriptor and saturated counts, then go to BOUND.
  - Mask bits at or above num_counters and targets at or above num_counters are ignored (treated as 0).
  - Buttons at or above num_buttons are never pressed.
- BOUND (1 cycle):
  - bound[i] = min target[j] over used counters j with mask bit i set.
  - bound[i]=0 for a button touching no used counter.
  - Press counters cleared; best=all-ones; iter=0. Go to SEARCH.
- SEARCH, one combination per cycle:
  - sum[j] = sum over used i with mask bit set of press[i]; cnt = sum of press[i].
  - If sum[j]==target[j] for all used j and cnt<best, then best<=cnt.
  - Odometer step: press[0]++. Any digit exceeding its bound resets to 0 and carries into the next digit.
  - Carry out of the top used digit (or num_buttons==0, one evaluation only) means the search is complete: go to REPORT.
  - iter increments each cycle. If iter reaches MAX_ITER-1 without completing, set timeout and go to REPORT after evaluating that combination.
- REPORT:
  - out_valid=1. out_presses=best. out_infeasible = (best==all-ones) && !timeout. out_timeout latched.
  - Outputs are held stable until out_ready.
  - On handshake: total += best only if best != all-ones (a partial best under timeout is still added). Then:
    - If in_last, set finished=1 and go to IDLE.
    - Otherwise go to IDLE.
  - finished stays set until clear or reset. A new descriptor after finished is accepted normally.
- Latency: result valid at capture + 2 + (number of combinations) cycles. in_ready=0 from capture until the REPORT handshake, so there is no overlap.
- Arithmetic:
  - sum[j] and cnt use CNT_W+4 bits, which cannot overflow for the given bounds.
  - total wraps modulo 2^SUM_W.
- Boundary cases:
  - All targets zero gives best=0.
  - A used counter with target>0 touched by no button gives infeasible.
  - num_counters=0 gives best=0.
  - out_ready held high makes REPORT last exactly 1 cycle.
  - clear outside IDLE is ignored.

Test Plan:
- Buttons {3},{1,3},{2},{2,3},{0,2},{0,1}, targets {3,5,4,7}, in_last=0 -> out_presses=10, flags 0, total=10.
- Then buttons {0,2,3,4},{2,3},{0,4},{0,1,2},{1,2,3,4}, targets {7,5,12,7,2} -> 12. Then buttons {0,1,2,3,4},{0,3,4},{0,1,2,4,5},{1,2}, targets {10,11,11,5,10,5}, in_last=1 -> 11, total=33, finished=1.
- Buttons {0}, targets {0,4} with num_counters=2 -> out_infeasible=1, out_presses=all-ones, total unchanged.
- All targets 0, 3 buttons -> out_presses=0 after exactly 1 SEARCH cycle; out_ready held low for 5 cycles -> outputs stable, in_ready=0.
- MAX_ITER=16 with the first test machine -> out_timeout=1, out_infeasible=0; a subsequent machine is processed normally.
- rst pulsed mid-SEARCH -> all outputs at reset values, no out_valid; clear in IDLE after finished -> total=0, finished=0.
